// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and a sequential clear sweep.
// Define RF_FWD_EN to bypass same-cycle write data onto the read ports.
module regfile_mp #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int NRD     = 2,
   parameter int NWR     = 2,
   parameter int ZERO_R0 = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clr_req,
   output logic                 o_busy,
   input  logic [NWR-1:0]       i_we,
   input  logic [NWR*AW-1:0]    i_waddr,
   input  logic [NWR*DW-1:0]    i_wdata,
   input  logic [NRD-1:0]       i_re,
   input  logic [NRD*AW-1:0]    i_raddr,
   output logic [NRD*DW-1:0]    o_rdata,
   input  logic                 i_sb_set,
   input  logic [AW-1:0]        i_sb_addr,
   output logic [NRD-1:0]       o_pend
);

   localparam int             DEPTH    = 1 << AW;
   localparam logic [0:0]     ST_IDLE  = 1'b0;
   localparam logic [0:0]     ST_SWEEP = 1'b1;
   localparam logic [AW-1:0]  PTR_LAST = {AW{1'b1}};
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic           R0_HARD  = (ZERO_R0 != 0);

   logic [0:0]       r_state;
   logic [AW-1:0]    r_ptr;
   logic [DEPTH-1:0] r_sb;
   logic [DW-1:0]    r_mem [DEPTH];

   logic             w_idle;
   logic [AW-1:0]    w_waddr [NWR];
   logic [DW-1:0]    w_wdata [NWR];
   logic [NWR-1:0]   w_wacc;
   logic             w_sb_acc;
   logic [DEPTH-1:0] w_sb_next;

   assign w_idle = (r_state == ST_IDLE);
   assign o_busy = ~w_idle;

   // Writes are only accepted in IDLE; r0 writes vanish when r0 is hardwired.
   for (genvar k = 0; k < NWR; k++) begin : g_wr
      assign w_waddr[k] = i_waddr[k*AW +: AW];
      assign w_wdata[k] = i_wdata[k*DW +: DW];
      assign w_wacc[k]  = i_we[k] & w_idle & ~(R0_HARD & (w_waddr[k] == '0));
   end

   assign w_sb_acc = i_sb_set & w_idle & ~(R0_HARD & (i_sb_addr == '0));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_SWEEP;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            ST_SWEEP: begin
               if (r_ptr == PTR_LAST) begin
                  r_state <= ST_IDLE;
               end
               r_ptr <= r_ptr + PTR_ONE;
            end
            ST_IDLE: begin
               if (i_clr_req) begin
                  r_state <= ST_SWEEP;
                  r_ptr   <= '0;
               end
            end
            default: begin
               r_state <= ST_SWEEP;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   // Later clears then the set, so a same-cycle set beats the writeback clear.
   always_comb begin
      w_sb_next = r_sb;
      for (int k = 0; k < NWR; k++) begin
         if (w_wacc[k]) begin
            w_sb_next[w_waddr[k]] = 1'b0;
         end
      end
      if (w_sb_acc) begin
         w_sb_next[i_sb_addr] = 1'b1;
      end
      if (R0_HARD) begin
         w_sb_next[0] = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sb <= '0;
      end else if (!w_idle || i_clr_req) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sb_next;
      end
   end

   // Storage carries no reset so it maps onto distributed RAM; the sweep zeroes it.
   always_ff @(posedge i_clk) begin
      if (!w_idle) begin
         r_mem[r_ptr] <= '0;
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (w_wacc[k]) begin
               r_mem[w_waddr[k]] <= w_wdata[k];
            end
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_raddr;
      logic          w_rzero;
      logic [DW-1:0] w_rd;
      logic          w_hit;

      assign w_raddr = i_raddr[i*AW +: AW];
      assign w_rzero = R0_HARD & (w_raddr == '0);

      // Ascending scan lets the highest-indexed matching write port win the bypass.
      always_comb begin
         w_rd  = r_mem[w_raddr];
         w_hit = 1'b0;
`ifdef RF_FWD_EN
         for (int k = 0; k < NWR; k++) begin
            if (w_wacc[k] && (w_waddr[k] == w_raddr)) begin
               w_rd  = w_wdata[k];
               w_hit = 1'b1;
            end
         end
`endif
         if (!w_idle || !i_re[i] || w_rzero) begin
            w_rd = '0;
         end
      end

      assign o_rdata[i*DW +: DW] = w_rd;
      assign o_pend[i] = i_re[i] & w_idle & ~w_rzero & r_sb[w_raddr] & ~w_hit;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic              clk = 1'b0;
   logic              rstN;
   logic              clrReq;
   logic              busy;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] waddr;
   logic [NWR*DW-1:0] wdata;
   logic [NRD-1:0]    re;
   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic              sbSet;
   logic [AW-1:0]     sbAddr;
   logic [NRD-1:0]    pend;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdlMem [32];
   bit          mdlSb  [32];
   int          sweepLeft;

   always #5 clk = ~clk;

   regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)) dut (
      .i_clk     (clk),
      .i_rst_n   (rstN),
      .i_clr_req (clrReq),
      .o_busy    (busy),
      .i_we      (we),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_re      (re),
      .i_raddr   (raddr),
      .o_rdata   (rdata),
      .i_sb_set  (sbSet),
      .i_sb_addr (sbAddr),
      .o_pend    (pend)
   );

   task automatic modelStartSweep();
      for (int a = 0; a < 32; a++) begin
         mdlMem[a] = 32'h0;
         mdlSb[a]  = 1'b0;
      end
      sweepLeft = 32;
   endtask

   task automatic modelUpdate();
      int a;
      if (sweepLeft > 0) begin
         sweepLeft--;
      end else if (clrReq) begin
         modelStartSweep();
      end else begin
         for (int k = 0; k < NWR; k++) begin
            a = int'(waddr[k*AW +: AW]);
            if (we[k] && a != 0) begin
               mdlMem[a] = wdata[k*DW +: DW];
               mdlSb[a]  = 1'b0;
            end
         end
         if (sbSet && sbAddr != 0) mdlSb[int'(sbAddr)] = 1'b1;
      end
   endtask

   task automatic modelRead(input int i, output logic [31:0] d, output logic p);
      int a;
      a = int'(raddr[i*AW +: AW]);
      d = 32'h0;
      p = 1'b0;
      if (sweepLeft == 0 && re[i] && a != 0) begin
         d = mdlMem[a];
         p = mdlSb[a];
`ifdef RF_FWD_EN
         for (int k = 0; k < NWR; k++) begin
            if (we[k] && int'(waddr[k*AW +: AW]) == a) begin
               d = wdata[k*DW +: DW];
               p = 1'b0;
            end
         end
`endif
      end
   endtask

   task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] expData;
      logic        expPend;
      expectEq({tag, ".busy"}, {31'h0, busy}, {31'h0, sweepLeft > 0});
      for (int i = 0; i < NRD; i++) begin
         modelRead(i, expData, expPend);
         expectEq($sformatf("%s.rdata%0d", tag, i), rdata[i*DW +: DW], expData);
         expectEq($sformatf("%s.pend%0d", tag, i), {31'h0, pend[i]}, {31'h0, expPend});
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the model with the edge.
   task automatic applyStimulus(input string tag);
      if (!rstN) modelStartSweep();
      #1;
      checkOutput(tag);
      @(posedge clk);
      if (rstN) modelUpdate();
      @(negedge clk);
   endtask

   task automatic idleInputs();
      clrReq = 1'b0;
      we     = '0;
      waddr  = '0;
      wdata  = '0;
      re     = '0;
      raddr  = '0;
      sbSet  = 1'b0;
      sbAddr = '0;
   endtask

   task automatic setWrite(input int k, input int a, input logic [31:0] d);
      we[k]             = 1'b1;
      waddr[k*AW +: AW] = AW'(a);
      wdata[k*DW +: DW] = d;
   endtask

   task automatic setRead(input int i, input int a);
      re[i]             = 1'b1;
      raddr[i*AW +: AW] = AW'(a);
   endtask

   task automatic randomInputs(input bit clrOk);
      we     = NWR'($urandom);
      waddr  = (NWR*AW)'($urandom);
      wdata  = {$urandom, $urandom};
      re     = NRD'($urandom);
      raddr  = (NRD*AW)'($urandom);
      sbSet  = 1'($urandom);
      sbAddr = AW'($urandom);
      clrReq = clrOk && ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      rstN = 1'b0;
      idleInputs();
      re = '1;
      @(negedge clk);
      repeat (3) applyStimulus("reset");

      // Sweep after release: busy for 32 edges, reads forced to zero, writes ignored.
      rstN = 1'b1;
      for (int c = 0; c < 32; c++) begin
         randomInputs(1'b0);
         clrReq = 1'b0;
         #1 expectEq("sweepBusy", {31'h0, busy}, 32'h1);
         applyStimulus("sweep");
      end
      idleInputs();
      #1 expectEq("sweepDone", {31'h0, busy}, 32'h0);
      for (int a = 1; a < 32; a++) begin
         setRead(0, a);
         setRead(1, 32 - a);
         #1 expectEq("postSweepZero", rdata[31:0], 32'h0);
         applyStimulus("postSweep");
      end

      // Same-address dual write: port 1 wins; r0 stays zero.
      idleInputs();
      setWrite(0, 5, 32'hAAAA_0001);
      setWrite(1, 5, 32'h5555_0002);
      applyStimulus("dualWr");
      idleInputs();
      setRead(0, 5);
      #1 expectEq("dualWrWinner", rdata[31:0], 32'h5555_0002);
      applyStimulus("dualRd");
      setWrite(0, 0, 32'hFFFF_FFFF);
      applyStimulus("r0Wr");
      idleInputs();
      setRead(0, 0);
      #1 expectEq("r0Zero", rdata[31:0], 32'h0);
      applyStimulus("r0Rd");

      // Read r7 while it is being written on port 0.
      setWrite(0, 7, 32'h0BAD_0007);
      applyStimulus("r7Init");
      idleInputs();
      setWrite(0, 7, 32'h1234_5678);
      setRead(1, 7);
`ifdef RF_FWD_EN
      #1 expectEq("fwdData", rdata[63:32], 32'h1234_5678);
`else
      #1 expectEq("noFwdData", rdata[63:32], 32'h0BAD_0007);
`endif
      expectEq("fwdPend", {31'h0, pend[1]}, 32'h0);
      applyStimulus("fwd");
      idleInputs();
      setRead(1, 7);
      #1 expectEq("r7After", rdata[63:32], 32'h1234_5678);
      applyStimulus("r7After");

      // Scoreboard: pending until writeback commits; same-cycle set beats clear.
      idleInputs();
      sbSet  = 1'b1;
      sbAddr = 5'd9;
      applyStimulus("sbSet");
      idleInputs();
      setRead(0, 9);
      #1 expectEq("sbPend", {31'h0, pend[0]}, 32'h1);
      applyStimulus("sbPend1");
      applyStimulus("sbPend2");
      setWrite(1, 9, 32'h0000_0999);
      applyStimulus("sbWb");
      idleInputs();
      setRead(0, 9);
      #1 expectEq("sbCleared", {31'h0, pend[0]}, 32'h0);
      applyStimulus("sbCleared");
      setWrite(0, 9, 32'h0000_0998);
      sbSet  = 1'b1;
      sbAddr = 5'd9;
      applyStimulus("sbSetWins");
      idleInputs();
      setRead(0, 9);
      #1 expectEq("sbSetWinsPend", {31'h0, pend[0]}, 32'h1);
      applyStimulus("sbSetWinsRd");

      // Random traffic with occasional clear sweeps.
      for (int c = 0; c < 500; c++) begin
         randomInputs(1'b1);
         applyStimulus("random");
      end

      // Fill, clear, attempt writes during the sweep, verify all zero.
      idleInputs();
      for (int c = 0; c < 40 && sweepLeft > 0; c++) applyStimulus("drain");
      for (int a = 1; a < 32; a++) begin
         idleInputs();
         setWrite(0, a, $urandom | 32'h1);
         applyStimulus("fill");
      end
      idleInputs();
      clrReq = 1'b1;
      applyStimulus("clrReq");
      for (int c = 0; c < 32; c++) begin
         randomInputs(1'b0);
         clrReq = 1'b1;
         #1 expectEq("clrBusy", {31'h0, busy}, 32'h1);
         applyStimulus("clrSweep");
      end
      idleInputs();
      for (int a = 1; a < 32; a++) begin
         setRead(0, a);
         setRead(1, a);
         #1 expectEq("clrZero", rdata[31:0], 32'h0);
         applyStimulus("clrRead");
      end

      // Reset at sweep cycle 10 restarts a full 32-edge sweep with a clean scoreboard.
      idleInputs();
      sbSet  = 1'b1;
      sbAddr = 5'd12;
      applyStimulus("preSb");
      idleInputs();
      clrReq = 1'b1;
      applyStimulus("clr2");
      idleInputs();
      repeat (10) applyStimulus("clr2Sweep");
      rstN = 1'b0;
      repeat (2) applyStimulus("midReset");
      rstN = 1'b1;
      for (int c = 0; c < 32; c++) begin
         randomInputs(1'b0);
         #1 expectEq("restartBusy", {31'h0, busy}, 32'h1);
         applyStimulus("restart");
      end
      idleInputs();
      setRead(0, 12);
      #1 expectEq("restartSb", {31'h0, pend[0]}, 32'h0);
      expectEq("restartIdle", {31'h0, busy}, 32'h0);
      applyStimulus("restartRd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
